// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - 16x-oversampled UART receiver (8N1 default) with framing-error flag
module uart_rx_os #(
  parameter int DBIT    = 8,
  parameter int OS      = 16,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            busy
);

  localparam int SMAX = (OS > SB_TICK) ? OS : SB_TICK;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // Terminal counts: half a bit to reach mid-start, a full bit between
  // data samples, and the stop period length.
  localparam logic [SW-1:0] S_HALF = SW'(OS / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic            rx_meta;
  logic            rx_s;
  logic [1:0]      state, state_n;
  logic [SW-1:0]   s, s_n;
  logic [NW-1:0]   n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic            load;

  // Two-flop synchroniser for the asynchronous serial line; resets to idle-high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Next-state logic: counters only move on oversample ticks; IDLE reacts
  // to the falling edge without waiting for a tick.
  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    b_n     = b;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == S_HALF) begin
            if (!rx_s) begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            s_n         = '0;
            b_n         = b >> 1;
            b_n[DBIT-1] = rx_s;
            if (n == N_LAST) begin
              state_n = STOP;
            end else begin
              n_n = n + 1'b1;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == S_STOP) begin
            load    = 1'b1;
            state_n = IDLE;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and outputs; dout/frame_err only change when a frame completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      busy         <= 1'b0;
      rx_done_tick <= 1'b0;
      dout         <= '0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_n;
      s            <= s_n;
      n            <= n_n;
      b            <= b_n;
      busy         <= (state_n != IDLE);
      rx_done_tick <= load;
      if (load) begin
        dout      <= b;
        frame_err <= ~rx_s;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - scoreboard bench for uart_rx_os
module tb_uart_rx_os;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       busy;

  logic       tick_en;
  int         tcnt;
  int         total;
  int         bad;
  int         pulses;
  logic       prev_done;
  exp_t       q[$];

  uart_rx_os #(.DBIT(8), .OS(16), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oversample tick every 4 clocks, changed on the falling edge.
  initial begin
    s_tick = 1'b0;
    tcnt   = 0;
    forever begin
      @(negedge clk);
      tcnt   = (tcnt == 3) ? 0 : tcnt + 1;
      s_tick = tick_en && (tcnt == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int k);
    int c;
    c = 0;
    while (c < k) begin
      @(posedge clk);
      if (s_tick) c++;
    end
    #1;
  endtask

  // One frame; a low stop bit is held only 10 ticks so the receiver's
  // restart after the bad stop is dropped by its half-bit glitch check.
  task automatic send_frame(input logic [7:0] data, input logic stop_val,
                            input int stall_bit, input int gap);
    exp_t e;
    e.data = data;
    e.ferr = ~stop_val;
    q.push_back(e);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      if (i == stall_bit) begin
        wait_ticks(8);
        @(negedge clk);
        tick_en = 1'b0;
        repeat (200) @(negedge clk);
        check("stall_busy", busy, 1);
        tick_en = 1'b1;
        wait_ticks(8);
      end else begin
        wait_ticks(16);
      end
    end
    if (stop_val) begin
      rx = 1'b1;
      wait_ticks(16);
    end else begin
      rx = 1'b0;
      wait_ticks(10);
      rx = 1'b1;
      wait_ticks(6);
    end
    if (gap > 0) wait_ticks(gap);
  endtask

  // Output monitor: every done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (prev_done) check("done_width", rx_done_tick, 0);
    if (rx_done_tick) begin
      pulses++;
      check("busy_at_done", busy, 0);
      if (q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("dout", dout, e.data);
        check("frame_err", frame_err, e.ferr);
      end
    end
    prev_done = rx_done_tick;
  end

  initial begin
    int guard;
    total     = 0;
    bad       = 0;
    pulses    = 0;
    prev_done = 1'b0;
    tick_en   = 1'b1;
    rx        = 1'b1;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_done", rx_done_tick, 0);
    reset = 1'b0;
    wait_ticks(8);

    // 1) clean frame
    send_frame(8'h55, 1'b1, -1, 4);
    check("t1_busy_after", busy, 0);

    // 2) short start glitch
    rx = 1'b0;
    wait_ticks(3);
    rx = 1'b1;
    wait_ticks(16);
    check("t2_busy", busy, 0);
    check("t2_dout_hold", dout, 8'h55);
    check("t2_pulses", pulses, 1);

    // 3) framing error then a good frame
    send_frame(8'hA3, 1'b0, -1, 8);
    check("t3_ferr_hold", frame_err, 1);
    send_frame(8'h0F, 1'b1, -1, 4);

    // 4) back-to-back, no idle gap
    send_frame(8'h00, 1'b1, -1, 0);
    send_frame(8'hFF, 1'b1, -1, 4);

    // 5) reset after four data bits
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h3C >> i) & 1'b1;
      wait_ticks(16);
    end
    @(negedge clk);
    check("t5_busy_pre", busy, 1);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_dout_clr", dout, 0);
    check("t5_ferr_clr", frame_err, 0);
    reset = 1'b0;
    wait_ticks(16);
    check("t5_pulses", pulses, 5);
    send_frame(8'h3C, 1'b1, -1, 4);

    // 6) tick stall in the middle of DATA
    send_frame(8'h5A, 1'b1, 3, 4);

    guard = 0;
    while (q.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("drain", q.size(), 0);
    check("pulse_count", pulses, 7);
    check("final_dout", dout, 8'h5A);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
